counter_chain_sequencer: RTL and testbench
==========================================

// Module: counter_chain_sequencer
// PURPOSE
//  Run-control sequencer for the cascaded N-bit counter chain. Generates the prescaled
//  enable for stage 0 and the chain-wide synchronous clear. Handles start/stop/clear
//  commands, ends the run at a programmable limit and flags chain overflow.
//  Exports a snapshot of the chain count through a valid/ready handshake.
//  Sits between the board-level key/command logic and the counter chain.
// PARAMETERS
//  CHAIN_W     32  total chain count width (stages x stage width), read from chain_count
//  PRESCALE_W  16  width of the internal prescaler; enable period = prescale_max+1 clk
// PORTS
//  clk            in   1           system clock (50 MHz board clock)
//  reset_n        in   1           asynchronous, active-low reset
//  cmd_start      in   1           1-cycle pulse: begin/resume counting
//  cmd_stop       in   1           1-cycle pulse: pause counting
//  cmd_clear      in   1           1-cycle pulse: zero the chain, return to IDLE
//  prescale_max   in   PRESCALE_W  prescaler terminal value; sampled on each prescaler wrap
//  run_limit      in   CHAIN_W     count at which the run ends; 0 = free-run (no limit)
//  chain_count    in   CHAIN_W     concatenated stage counts, stage 0 in LSBs
//  chain_tc       in   1           AND of all stage terminal counts (full chain at max)
//  chain_enable   out  1           enable to stage 0 of the chain
//  chain_clear    out  1           synchronous clear to every stage
//  running        out  1           1 while in RUN
//  done           out  1           1-cycle pulse when run_limit is reached
//  overflow       out  1           sticky: chain wrapped from all-ones to zero
//  snap_req       in   1           1-cycle pulse: capture chain_count
//  snap_data      out  CHAIN_W     captured count, stable while snap_valid=1
//  snap_valid     out  1           snapshot available
//  snap_ready     in   1           consumer accepts snapshot when valid&ready
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, prescaler=0; all outputs 0; snap_data=0.
//  FSM states: IDLE, RUN, PAUSE, DONE, CLR. All transitions registered.
//   Command priority in one cycle: clear > stop > start.
//   Any state + cmd_clear -> CLR. CLR asserts chain_clear for exactly one cycle.
//    CLR also clears overflow and the prescaler, then goes to IDLE.
//   IDLE + start -> RUN.  PAUSE + start -> RUN.  RUN + stop -> PAUSE.
//   RUN + limit hit -> DONE. DONE ignores start/stop; only clear leaves DONE.
//   Start while in RUN and stop while in IDLE/PAUSE/DONE are no-ops.
//  Prescaler: counts only in RUN. chain_enable=1 for the single cycle in which
//   prescaler==prescale_max; the prescaler then wraps to 0.
//   prescale_max=0 -> chain_enable=1 every RUN cycle.
//   PAUSE holds the prescaler value, so resume keeps the phase.
//  Limit: run_limit!=0 and chain_count==run_limit and state==RUN.
//   In that case the FSM enters DONE next cycle, done pulses 1 cycle, chain_enable=0.
//   The count therefore stops exactly at run_limit.
//  Overflow: set when chain_enable=1 and chain_tc=1 in the same cycle.
//   Cleared only by CLR or reset. A limit hit and chain_tc in the same cycle -> DONE wins.
//   Overflow is still set only if chain_enable was 1 in that cycle.
//  Snapshot: snap_req with snap_valid=0 -> next cycle snap_data=chain_count, snap_valid=1.
//   snap_valid stays 1 until snap_valid&snap_ready. snap_req while valid is dropped;
//   data is not overwritten. snap_req in the same cycle as the accept is honoured.
//   Snapshots work in every state, including CLR, where they capture the pre-clear count.
//  Reset mid-run: chain_enable deasserts asynchronously; the chain is not cleared.
//   Software must issue cmd_clear.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3, CLR=4)
//   and the 1'b1 "enable-default" constant.
//  One sub-module: prescale_tick (PRESCALE_W counter, run/hold/clear -> tick).
//  The snapshot register stays inline.
// TESTING
//  1 prescale_max=3, start -> chain_enable high on cycles 4,8,12 after RUN entry.
//    running=1 throughout.
//  2 prescale_max=3, stop after 2 enables, start 10 cycles later.
//    Next enable arrives 4 cycles after RUN re-entry minus the held phase.
//  3 run_limit=5, prescale_max=0 -> chain_count stops at 5, done 1-cycle pulse.
//    running=0; start ignored until clear.
//  4 chain_count=all-ones, chain_tc=1 with an enable -> overflow=1 and stays sticky.
//    clear -> chain_clear 1 cycle, overflow=0, state IDLE.
//  5 snap_req at count 0x10 with snap_ready=0 for 5 cycles and a 2nd snap_req.
//    Expect snap_data=0x10 held; accepted on ready; 2nd request dropped.
//  6 cmd_start+cmd_stop+cmd_clear in the same cycle -> CLR.
//    reset_n pulse mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/counter_chain_sequencer_pkg.sv
// Shared definitions for the counter chain run-control sequencer.
package counter_chain_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3,
    ST_CLR   = 3'd4
  } seq_state_t;

  // Value driven onto an enable-style output when it is asserted.
  localparam logic ENABLE_DEFAULT = 1'b1;

endpackage

// File: rtl/counter_chain_sequencer_if.sv
// Snapshot handshake between the sequencer (master, produces the captured
// count) and its consumer (slave, requests and accepts snapshots).
interface counter_chain_sequencer_if #(
  parameter int CHAIN_W = 32
);

  logic               snap_req;
  logic [CHAIN_W-1:0] snap_data;
  logic               snap_valid;
  logic               snap_ready;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_data,
    output snap_valid
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_data,
    input  snap_valid
  );

endinterface

// File: rtl/counter_chain_sequencer_prescale_tick.sv
// Prescaler for the chain enable: counts while running, holds while paused,
// and produces a one-cycle tick when it reaches its terminal value.
module prescale_tick #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale_max,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] max_q;
  logic [PRESCALE_W-1:0] term_value;

  // The terminal value is taken live at the start of each period and held for the rest of it.
  always_comb begin
    term_value = max_q;
    if (count_q == '0) begin
      term_value = prescale_max;
    end
  end

  assign tick = run && (count_q == term_value);

  // Advance the prescaler only while running; wrap to zero on the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      max_q   <= '0;
    end else if (clear) begin
      count_q <= '0;
      max_q   <= '0;
    end else if (run) begin
      if (count_q == '0) begin
        max_q <= prescale_max;
      end
      if (tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_chain_sequencer.sv
// Run-control sequencer for the cascaded counter chain: start/stop/clear
// handling, prescaled stage-0 enable, run limit, overflow flag and a
// valid/ready snapshot of the chain count.
module counter_chain_sequencer
  import counter_chain_sequencer_pkg::*;
#(
  parameter int CHAIN_W    = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_clear,
  input  logic [PRESCALE_W-1:0] prescale_max,
  input  logic [CHAIN_W-1:0]    run_limit,
  input  logic [CHAIN_W-1:0]    chain_count,
  input  logic                  chain_tc,
  output logic                  chain_enable,
  output logic                  chain_clear,
  output logic                  running,
  output logic                  done,
  output logic                  overflow,
  counter_chain_sequencer_if.master snap_if
);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic               limit_hit;
  logic               tick;
  logic               done_q;
  logic               overflow_q;
  logic [CHAIN_W-1:0] snap_data_q;
  logic               snap_valid_q;

  assign limit_hit = (run_limit != '0) && (chain_count == run_limit) && (state_q == ST_RUN);

  prescale_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (state_q == ST_RUN),
    .clear        (state_q == ST_CLR),
    .prescale_max (prescale_max),
    .tick         (tick)
  );

  // The enable is withheld in the limit cycle so the chain stops exactly on run_limit.
  assign chain_enable = tick && !limit_hit;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state with clear > stop > start; a limit hit takes precedence over stop.
  always_comb begin
    state_d     = state_q;
    running     = 1'b0;
    chain_clear = 1'b0;
    if (cmd_clear) begin
      state_d = ST_CLR;
    end else begin
      case (state_q)
        ST_IDLE:  if (cmd_start) state_d = ST_RUN;
        ST_RUN: begin
          if (limit_hit) begin
            state_d = ST_DONE;
          end else if (cmd_stop) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (cmd_start) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        ST_CLR:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    case (state_q)
      ST_RUN:  running     = ENABLE_DEFAULT;
      ST_CLR:  chain_clear = ENABLE_DEFAULT;
      default: ;
    endcase
  end

  // Pulse done for the single cycle following the limit hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_RUN) && (state_d == ST_DONE);
    end
  end

  // Sticky overflow, dropped as soon as a clear is commanded so it reads 0 throughout CLR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (cmd_clear || (state_q == ST_CLR)) begin
      overflow_q <= 1'b0;
    end else if (chain_enable && chain_tc) begin
      overflow_q <= 1'b1;
    end
  end

  // Snapshot holding register: capture when empty or being emptied this cycle, otherwise drop the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      if (snap_valid_q && snap_if.snap_ready) begin
        snap_valid_q <= 1'b0;
      end
      if (snap_if.snap_req && (!snap_valid_q || snap_if.snap_ready)) begin
        snap_data_q  <= chain_count;
        snap_valid_q <= 1'b1;
      end
    end
  end

  assign done               = done_q;
  assign overflow           = overflow_q;
  assign snap_if.snap_data  = snap_data_q;
  assign snap_if.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// Self-checking bench for counter_chain_sequencer. A behavioural counter
// chain closes the loop around the sequencer; snapshots are checked through
// a scoreboard queue filled when requests are driven.
module tb_counter_chain_sequencer;

  localparam int CHAIN_W    = 32;
  localparam int PRESCALE_W = 16;

  logic                  clk;
  logic                  reset_n;
  logic                  cmd_start;
  logic                  cmd_stop;
  logic                  cmd_clear;
  logic [PRESCALE_W-1:0] prescale_max;
  logic [CHAIN_W-1:0]    run_limit;
  logic [CHAIN_W-1:0]    chain_count;
  logic                  chain_tc;
  logic                  chain_enable;
  logic                  chain_clear;
  logic                  running;
  logic                  done;
  logic                  overflow;

  logic                  load_req;
  logic [CHAIN_W-1:0]    load_val;

  int check_count;
  int error_count;
  logic [CHAIN_W-1:0] snap_sb[$];

  counter_chain_sequencer_if #(.CHAIN_W(CHAIN_W)) snap_bus ();

  counter_chain_sequencer #(
    .CHAIN_W    (CHAIN_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_clear    (cmd_clear),
    .prescale_max (prescale_max),
    .run_limit    (run_limit),
    .chain_count  (chain_count),
    .chain_tc     (chain_tc),
    .chain_enable (chain_enable),
    .chain_clear  (chain_clear),
    .running      (running),
    .done         (done),
    .overflow     (overflow),
    .snap_if      (snap_bus)
  );

  // Free-running 100 MHz bench clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural counter chain: bench load, synchronous clear, otherwise count on enable.
  always @(posedge clk) begin
    if (load_req) begin
      chain_count <= load_val;
    end else if (chain_clear) begin
      chain_count <= '0;
    end else if (chain_enable) begin
      chain_count <= chain_count + 1'b1;
    end
  end

  assign chain_tc = &chain_count;

  // Snapshot consumer side: every accepted snapshot is compared with the oldest expected capture.
  always @(negedge clk) begin
    if (reset_n && snap_bus.snap_valid && snap_bus.snap_ready) begin
      if (snap_sb.size() == 0) begin
        checkOutput("snap_sb_underflow", 32'(snap_sb.size()), 32'd1);
      end else begin
        checkOutput("snap_data_accept", snap_bus.snap_data, snap_sb.pop_front());
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tickCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic clear);
    cmd_start = start;
    cmd_stop  = stop;
    cmd_clear = clear;
    tickCycle();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_clear = 1'b0;
  endtask

  task automatic loadChain(input logic [CHAIN_W-1:0] value);
    load_val = value;
    load_req = 1'b1;
    tickCycle();
    load_req = 1'b0;
  endtask

  task automatic snapRequest(input logic expect_capture);
    snap_bus.snap_req = 1'b1;
    if (expect_capture) snap_sb.push_back(chain_count);
    tickCycle();
    snap_bus.snap_req = 1'b0;
  endtask

  task automatic clearToIdle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickCycle();
  endtask

  initial begin
    check_count         = 0;
    error_count         = 0;
    reset_n             = 1'b0;
    cmd_start           = 1'b0;
    cmd_stop            = 1'b0;
    cmd_clear           = 1'b0;
    prescale_max        = '0;
    run_limit           = '0;
    load_req            = 1'b0;
    load_val            = '0;
    chain_count         = '0;
    snap_bus.snap_req   = 1'b0;
    snap_bus.snap_ready = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_chain_enable", chain_enable, 0);
    checkOutput("rst_chain_clear", chain_clear, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_snap_valid", snap_bus.snap_valid, 0);
    checkOutput("rst_snap_data", snap_bus.snap_data, 0);
    tickCycle();
    tickCycle();
    reset_n = 1'b1;
    tickCycle();

    // Prescale by 4: enables on RUN cycles 4, 8, 12
    prescale_max = 16'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      checkOutput($sformatf("t1_enable_c%0d", i), chain_enable, (i % 4 == 0) ? 1 : 0);
      checkOutput("t1_running", running, 1);
      tickCycle();
    end
    checkOutput("t1_chain_count", chain_count, 3);

    // Pause holds the prescaler phase
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2_clr_chain_clear", chain_clear, 1);
    checkOutput("t2_clr_running", running, 0);
    tickCycle();
    checkOutput("t2_idle_chain_clear", chain_clear, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      checkOutput($sformatf("t2_enable_c%0d", i), chain_enable, (i % 4 == 0) ? 1 : 0);
      tickCycle();
    end
    checkOutput("t2_enable_c10", chain_enable, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      checkOutput("t2_pause_enable", chain_enable, 0);
      checkOutput("t2_pause_running", running, 0);
      tickCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      checkOutput($sformatf("t2_resume_enable_c%0d", i), chain_enable, (i == 2 || i == 6) ? 1 : 0);
      tickCycle();
    end
    checkOutput("t2_chain_count", chain_count, 4);

    // Run limit of 5 with no prescaling
    clearToIdle();
    prescale_max = 16'd0;
    run_limit    = 32'd5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("t3_enable_c%0d", i), chain_enable, 1);
      tickCycle();
    end
    checkOutput("t3_limit_enable", chain_enable, 0);
    checkOutput("t3_limit_running", running, 1);
    checkOutput("t3_limit_done", done, 0);
    tickCycle();
    checkOutput("t3_done_pulse", done, 1);
    checkOutput("t3_done_running", running, 0);
    checkOutput("t3_done_count", chain_count, 5);
    tickCycle();
    checkOutput("t3_done_low", done, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t3_start_ignored", running, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_stop_ignored_enable", chain_enable, 0);
    checkOutput("t3_count_held", chain_count, 5);

    // Overflow from all-ones, sticky until clear
    clearToIdle();
    run_limit = '0;
    loadChain(32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_wrap_enable", chain_enable, 1);
    checkOutput("t4_overflow_before", overflow, 0);
    tickCycle();
    checkOutput("t4_overflow_set", overflow, 1);
    checkOutput("t4_wrapped_count", chain_count, 0);
    for (int i = 0; i < 3; i++) begin
      tickCycle();
      checkOutput("t4_overflow_sticky", overflow, 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_overflow_pause", overflow, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_clr_chain_clear", chain_clear, 1);
    checkOutput("t4_clr_overflow", overflow, 0);
    tickCycle();
    checkOutput("t4_idle_chain_clear", chain_clear, 0);
    checkOutput("t4_idle_overflow", overflow, 0);
    checkOutput("t4_idle_running", running, 0);

    // Snapshot held under back-pressure; second request dropped
    loadChain(32'h10);
    snapRequest(1'b1);
    checkOutput("t5_snap_valid", snap_bus.snap_valid, 1);
    checkOutput("t5_snap_data", snap_bus.snap_data, 32'h10);
    loadChain(32'h20);
    snapRequest(1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_hold_valid", snap_bus.snap_valid, 1);
      checkOutput("t5_hold_data", snap_bus.snap_data, 32'h10);
      tickCycle();
    end
    snap_bus.snap_ready = 1'b1;
    tickCycle();
    snap_bus.snap_ready = 1'b0;
    checkOutput("t5_dropped_req", snap_bus.snap_valid, 0);
    snapRequest(1'b1);
    checkOutput("t5_second_data", snap_bus.snap_data, 32'h20);
    loadChain(32'h30);
    snap_bus.snap_ready = 1'b1;
    snapRequest(1'b1);
    snap_bus.snap_ready = 1'b0;
    checkOutput("t5_req_on_accept_valid", snap_bus.snap_valid, 1);
    checkOutput("t5_req_on_accept_data", snap_bus.snap_data, 32'h30);
    snap_bus.snap_ready = 1'b1;
    tickCycle();
    snap_bus.snap_ready = 1'b0;
    checkOutput("t5_final_valid", snap_bus.snap_valid, 0);
    checkOutput("t5_sb_drained", 32'(snap_sb.size()), 0);

    // All commands together go to CLR; async reset mid-run
    clearToIdle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tickCycle();
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6_all_cmd_clear", chain_clear, 1);
    checkOutput("t6_all_cmd_running", running, 0);
    tickCycle();
    checkOutput("t6_idle_clear", chain_clear, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tickCycle();
    tickCycle();
    tickCycle();
    snapRequest(1'b0);
    checkOutput("t6_snap_valid_pre", snap_bus.snap_valid, 1);
    checkOutput("t6_snap_data_pre", snap_bus.snap_data, 3);
    checkOutput("t6_enable_pre", chain_enable, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_enable", chain_enable, 0);
    checkOutput("t6_rst_running", running, 0);
    checkOutput("t6_rst_clear", chain_clear, 0);
    checkOutput("t6_rst_snap_valid", snap_bus.snap_valid, 0);
    checkOutput("t6_rst_snap_data", snap_bus.snap_data, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_overflow", overflow, 0);
    tickCycle();
    reset_n = 1'b1;
    tickCycle();
    checkOutput("t6_post_rst_running", running, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
